// File: rtl/hs_proto_engine_if.sv
// Request/handshake bundle between requesters, downstream unit and the engine.
// The master side drives requests; the slave side is the engine.
interface hs_proto_engine_if #(
  parameter int NCH   = 4,
  parameter int LEN_W = 4
);
  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]            req;
  logic [NCH-1:0][LEN_W-1:0] len;
  logic                      rdy_in;
  logic                      stop;
  logic                      rdy;
  logic                      start;
  logic                      busy;
  logic                      endd;
  logic                      er;
  logic                      rt;
  logic [NCH-1:0]            ack;
  logic [GW-1:0]             gnt_id;

  modport master (output req, len, rdy_in, stop,
                  input  rdy, start, busy, endd, er, rt, ack, gnt_id);
  modport slave  (input  req, len, rdy_in, stop,
                  output rdy, start, busy, endd, er, rt, ack, gnt_id);
endinterface

// File: rtl/hs_proto_engine.sv
// Round-robin multi-channel sequencer: grant, wait for downstream, run a burst,
// with wait timeout, bounded retry and stop abort. All outputs decode the state.
module hs_proto_engine #(
  parameter int NCH       = 4,
  parameter int LEN_W     = 4,
  parameter int TIMEOUT   = 15,
  parameter int MAX_RETRY = 2
) (
  input  logic               clk,
  input  logic               rst,
  hs_proto_engine_if.slave   bus
);
  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [7:0]    TO   = 8'(TIMEOUT);
  localparam logic [2:0]    MR   = 3'(MAX_RETRY);
  localparam logic [GW-1:0] LAST = GW'(NCH - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_START, S_BUSY, S_END, S_ERR} state_e;

  state_e           state_q, state_d;
  logic [GW-1:0]    ptr_q, ptr_d, gnt_q, gnt_d;
  logic [7:0]       wait_q, wait_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, lsel;
  logic [2:0]       retry_q, retry_d;
  logic [GW-1:0]    pick, nxt, idx;
  logic             found, can_retry;

  // First requester at or after ptr, circularly.
  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = GW'((int'(ptr_q) + k) % NCH);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign nxt       = (gnt_q == LAST) ? '0 : gnt_q + GW'(1);
  assign lsel      = bus.len[gnt_q];
  assign can_retry = (retry_q < MR);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    wait_d  = wait_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    case (state_q)
      S_IDLE: if (found) begin
        gnt_d   = pick;
        retry_d = '0;
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.rdy_in) state_d = S_START;
        else begin
          wait_d = wait_q + 8'd1;
          if (wait_d == TO) state_d = S_ERR;
        end
      end
      S_START: begin
        cnt_d   = (lsel == '0) ? LEN_W'(1) : lsel;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        if (bus.stop)                 state_d = S_ERR;
        else if (cnt_q == LEN_W'(1))  state_d = S_END;
        else                          cnt_d   = cnt_q - LEN_W'(1);
      end
      S_END: begin
        ptr_d   = nxt;
        state_d = S_IDLE;
      end
      S_ERR: begin
        if (can_retry) begin
          retry_d = retry_q + 3'd1;
          wait_d  = '0;
          state_d = S_WAIT;
        end else begin
          ptr_d   = nxt;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

  assign bus.rdy    = (state_q == S_IDLE);
  assign bus.start  = (state_q == S_START);
  assign bus.busy   = (state_q == S_BUSY);
  assign bus.endd   = (state_q == S_END);
  assign bus.er     = (state_q == S_ERR);
  assign bus.rt     = (state_q == S_ERR) && can_retry;
  // Ack on success, or on the final error when the channel is abandoned.
  assign bus.ack    = ((state_q == S_END) || ((state_q == S_ERR) && !can_retry))
                      ? (NCH'(1) << gnt_q) : '0;
  assign bus.gnt_id = gnt_q;
endmodule

// File: tb/tb_hs_proto_engine.sv
// Directed bench for hs_proto_engine: transaction-level model checked every
// cycle, plus hand-computed event timings for each scenario.
module tb_hs_proto_engine;
  localparam int NCH = 4, LEN_W = 4, TIMEOUT = 15, MAX_RETRY = 2;
  localparam int P_IDLE = 0, P_WAIT = 1, P_START = 2, P_BUSY = 3, P_END = 4, P_ERR = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hs_proto_engine_if #(.NCH(NCH), .LEN_W(LEN_W)) bus ();
  hs_proto_engine #(.NCH(NCH), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0, bad = 0, cyc = 0, mark = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cyc %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_ph, m_ch, m_ptr, m_wait, m_done, m_len, m_tries;

  function automatic int first_req(input logic [NCH-1:0] r, input int from);
    for (int k = 0; k < NCH; k++) if (r[(from + k) % NCH]) return (from + k) % NCH;
    return -1;
  endfunction

  function automatic int eff_len(input int l);
    return (l == 0) ? 1 : l;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ph <= P_IDLE; m_ch <= 0; m_ptr <= 0; m_wait <= 0;
      m_done <= 0; m_len <= 0; m_tries <= 0;
    end else begin
      case (m_ph)
        P_IDLE: if (first_req(bus.req, m_ptr) >= 0) begin
          m_ch <= first_req(bus.req, m_ptr); m_tries <= 0; m_wait <= 0; m_ph <= P_WAIT;
        end
        P_WAIT: if (bus.rdy_in) m_ph <= P_START;
                else begin
                  m_wait <= m_wait + 1;
                  if (m_wait + 1 >= TIMEOUT) m_ph <= P_ERR;
                end
        P_START: begin m_done <= 0; m_len <= eff_len(int'(bus.len[m_ch])); m_ph <= P_BUSY; end
        P_BUSY: if (bus.stop) m_ph <= P_ERR;
                else begin
                  m_done <= m_done + 1;
                  if (m_done + 1 == m_len) m_ph <= P_END;
                end
        P_END: begin m_ptr <= (m_ch + 1) % NCH; m_ph <= P_IDLE; end
        default: if (m_tries < MAX_RETRY) begin
                   m_tries <= m_tries + 1; m_wait <= 0; m_ph <= P_WAIT;
                 end else begin
                   m_ptr <= (m_ch + 1) % NCH; m_ph <= P_IDLE;
                 end
      endcase
    end
  end

  logic [NCH-1:0] exp_ack;
  logic [NCH+5:0] exp_vec, act_vec;
  assign exp_ack = ((m_ph == P_END) || (m_ph == P_ERR && m_tries >= MAX_RETRY))
                   ? NCH'(1 << m_ch) : '0;
  assign exp_vec = {m_ph == P_IDLE, m_ph == P_START, m_ph == P_BUSY, m_ph == P_END,
                    m_ph == P_ERR, (m_ph == P_ERR) && (m_tries < MAX_RETRY), exp_ack};
  assign act_vec = {bus.rdy, bus.start, bus.busy, bus.endd, bus.er, bus.rt, bus.ack};

  always @(negedge clk) begin
    check("cycle_outputs", int'(act_vec), int'(exp_vec));
    if (m_ph != P_IDLE) check("gnt_id", int'(bus.gnt_id), m_ch);
  end

  // ---------------- event logs ----------------
  int start_q[$], busy_q[$], endd_q[$], er_q[$], rt_q[$], ack_t_q[$], ack_v_q[$], gnt_q[$];
  always @(negedge clk) if (rst) begin
    if (bus.start) begin start_q.push_back(cyc - mark); gnt_q.push_back(int'(bus.gnt_id)); end
    if (bus.busy)  busy_q.push_back(cyc - mark);
    if (bus.endd)  endd_q.push_back(cyc - mark);
    if (bus.er)    er_q.push_back(cyc - mark);
    if (bus.rt)    rt_q.push_back(cyc - mark);
    if (|bus.ack) begin ack_t_q.push_back(cyc - mark); ack_v_q.push_back(int'(bus.ack)); end
  end

  task automatic clear_logs();
    start_q.delete(); busy_q.delete(); endd_q.delete(); er_q.delete();
    rt_q.delete(); ack_t_q.delete(); ack_v_q.delete(); gnt_q.delete();
    mark = cyc;
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Drive req at a negedge, hold until the ack pulse, then drop it.
  task automatic txn(input logic [NCH-1:0] r, input int budget, input string nm);
    bit got = 0;
    clear_logs();
    bus.req = r;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (|bus.ack) begin got = 1; break; end
    end
    bus.req = '0;
    check({nm, "_ack_seen"}, int'(got), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    bus.req = '0; bus.len = '0; bus.rdy_in = 1'b0; bus.stop = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rdy", int'(bus.rdy), 1);
    check("rst_outs", int'({bus.start, bus.busy, bus.endd, bus.er, bus.rt, bus.ack, bus.gnt_id}), 0);
    rst = 1'b1;
    @(negedge clk);

    // Round robin, all channels held, len=1 everywhere.
    for (int i = 0; i < NCH; i++) bus.len[i] = LEN_W'(1);
    bus.rdy_in = 1'b1;
    clear_logs();
    bus.req = '1;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (|bus.ack) begin n++; if (n == 5) break; end
    end
    bus.req = '0;
    repeat (2) @(negedge clk);
    check("rr_nack", ack_v_q.size(), 5);
    check("rr_first_ack", qat(ack_t_q, 0), 4);
    for (int i = 0; i < 5; i++) check("rr_order", qat(ack_v_q, i), 1 << (i % 4));
    for (int i = 1; i < 5; i++) check("rr_spacing", qat(ack_t_q, i) - qat(ack_t_q, i - 1), 5);

    // Single channel 2, len=3.
    bus.len[2] = LEN_W'(3);
    txn(4'b0100, 30, "single");
    check("single_start", qat(start_q, 0), 2);
    check("single_busy_n", busy_q.size(), 3);
    check("single_busy_first", qat(busy_q, 0), 3);
    check("single_busy_last", qat(busy_q, 2), 5);
    check("single_endd", qat(endd_q, 0), 6);
    check("single_ack_t", qat(ack_t_q, 0), 6);
    check("single_ack_v", qat(ack_v_q, 0), 4);
    check("single_gnt", qat(gnt_q, 0), 2);

    // len=0 behaves as len=1.
    bus.len[3] = '0;
    txn(4'b1000, 30, "len0");
    check("len0_busy_n", busy_q.size(), 1);
    check("len0_endd_gap", qat(endd_q, 0) - qat(start_q, 0), 2);

    // Timeout with retry: downstream never ready.
    bus.rdy_in = 1'b0;
    txn(4'b0001, 80, "tmo");
    check("tmo_n_er", er_q.size(), 3);
    check("tmo_er0", qat(er_q, 0), 16);
    check("tmo_er1", qat(er_q, 1), 32);
    check("tmo_er2", qat(er_q, 2), 48);
    check("tmo_n_rt", rt_q.size(), 2);
    check("tmo_rt1", qat(rt_q, 1), 32);
    check("tmo_ack_t", qat(ack_t_q, 0), 48);
    check("tmo_ack_v", qat(ack_v_q, 0), 1);
    check("tmo_no_start", start_q.size(), 0);

    // Stop on 4th busy cycle; stop while waiting is ignored.
    bus.rdy_in = 1'b1;
    bus.len[1] = LEN_W'(8);
    clear_logs();
    bus.req = 4'b0010;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      bus.stop = ((cyc - mark) == 1) || ((cyc - mark) == 6);
      if (|bus.ack) break;
    end
    bus.req = '0; bus.stop = 1'b0;
    repeat (2) @(negedge clk);
    check("stop_er", qat(er_q, 0), 7);
    check("stop_rt", qat(rt_q, 0), 7);
    check("stop_n_start", start_q.size(), 2);
    check("stop_restart", qat(start_q, 1), 9);
    check("stop_endd", qat(endd_q, 0), 18);
    check("stop_ack_v", qat(ack_v_q, 0), 2);

    // Async reset in BUSY, then a pending request restarts from channel 0.
    bus.len[1] = LEN_W'(5);
    clear_logs();
    bus.req = 4'b0010;
    repeat (4) @(negedge clk);
    check("rstb_in_busy", int'(bus.busy), 1);
    #2 rst = 1'b0;
    #1;
    check("rstb_rdy", int'(bus.rdy), 1);
    check("rstb_outs", int'({bus.start, bus.busy, bus.endd, bus.er, bus.rt, bus.ack, bus.gnt_id}), 0);
    bus.req = 4'b1011;
    @(negedge clk);
    check("rstb_no_ack", ack_t_q.size(), 0);
    rst = 1'b1;
    clear_logs();
    @(negedge clk);
    check("rstb_gnt0", int'(bus.gnt_id), 0);
    check("rstb_granted", int'(bus.rdy), 0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (|bus.ack) break;
    end
    bus.req = '0;
    repeat (2) @(negedge clk);
    check("rstb_ack_v", qat(ack_v_q, 0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/hs_proto_engine.md
Name: hs_proto_engine

Overview:
- Parametrised multi-channel transaction engine generalising the single-instance protocol cases (rdy/start/endd, req/ack, er/rt, stop) into one block.
- NCH requesters compete for one shared downstream unit. The round-robin winner is run through a start/busy/end sequence with a programmable length.
- Wait timeout, bounded retry and abort on stop are supported.
- Used as the protocol-correct DUT for the team's formal property suites and as a reusable arbiter/sequencer in RTL.

Parameters:
- NCH, 4: number of requesting channels (2..16).
- LEN_W, 4: width of the per-channel burst length field.
- TIMEOUT, 15: maximum cycles spent in WAIT before an error (1..255).
- MAX_RETRY, 2: retries allowed after an error before the transaction is abandoned (0..7).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- req  in  NCH  per-channel request level; held by the requester until its ack.
- len  in  NCH*LEN_W  per-channel burst length; channel i uses bits [i*LEN_W +: LEN_W].
- rdy_in  in  1  downstream unit ready.
- stop  in  1  abort request for the transaction in progress.
- rdy  out  1  engine idle; high only in IDLE.
- start  out  1  one-cycle pulse marking transaction start.
- busy  out  1  high throughout BUSY.
- endd  out  1  one-cycle pulse on successful completion.
- er  out  1  one-cycle error pulse.
- rt  out  1  one-cycle retry pulse.
- ack  out  NCH  one-hot, one-cycle completion/abandon pulse to the granted channel.
- gnt_id  out  clog2(NCH)  index of the granted channel; valid whenever the state is not IDLE.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE; rdy=1.
  - start, busy, endd, er, rt, ack and gnt_id are all 0.
  - The round-robin pointer is 0; the wait, length and retry counters are 0.
- Reset mid-transaction aborts immediately with no ack. After release the engine is in IDLE.
- All outputs are registered or decoded from the registered state (Moore).
- IDLE:
  - If |req, grant the first requesting channel at or after ptr in circular order.
  - Latch gnt_id, clear the retry and wait counters, go to WAIT.
- WAIT:
  - If rdy_in=1, go to START.
  - Otherwise increment the wait counter; when it reaches TIMEOUT, go to ERR.
- START:
  - start=1 for this one cycle.
  - Load cnt = len[gnt_id]; a length of 0 is treated as 1.
  - Go to BUSY.
- BUSY:
  - busy=1. stop=1 takes priority and sends the engine to ERR.
  - Otherwise, if cnt==1 go to END, else decrement cnt.
  - BUSY therefore lasts exactly L cycles, where L is the effective length.
- END:
  - endd=1 and ack[gnt_id]=1 in the same cycle.
  - ptr = gnt_id+1 mod NCH; go to IDLE.
- ERR:
  - er=1.
  - If retry < MAX_RETRY: rt=1, retry++, wait counter cleared, go to WAIT on the same channel.
  - Otherwise: ack[gnt_id]=1 (abandon), ptr advances as in END, go to IDLE.
- Timing:
  - req rising in IDLE at cycle 0: WAIT at cycle 1. With rdy_in already 1, START at cycle 2, BUSY at cycles 3..2+L, END at cycle 3+L.
  - One idle cycle always separates transactions; IDLE is a single cycle when req is pending.
- Edge cases:
  - stop outside BUSY is ignored.
  - req deasserted after grant is ignored; the transaction runs to completion.
  - A new req on another channel does not preempt the transaction in progress.
  - rdy_in is sampled only in WAIT.
  - len is sampled only in START.
- Protocol invariants (formal targets):
  - At most one of start/endd/er is high in any cycle.
  - ack is one-hot or zero.
  - endd implies ack.
  - rt implies er.
  - busy implies !rdy.
  - Each start is followed by exactly one of endd or er within L+1 cycles.
  - A requester holding req is granted within NCH transactions (no starvation).

Test Plan:
- Single channel: req[2]=1, len[2]=3, rdy_in=1 → start at cycle 2, busy cycles 3-5, endd and ack=4'b0100 at cycle 6, gnt_id=2.
- Round robin: req=4'b1111 held, all len=1 → grant order 0,1,2,3,0; each ack 5 cycles apart.
- Timeout with retry: rdy_in=0 throughout, TIMEOUT=15, MAX_RETRY=2.
  - Three er pulses with rt on the first two.
  - ack on the third er; no start seen.
- Stop abort: len=8, stop=1 on the 4th BUSY cycle → er next cycle, rt=1, back to WAIT. With rdy_in=1, start reissues.
- len=0 → treated as 1: one busy cycle, endd 2 cycles after start.
- Async reset asserted during BUSY → all outputs 0 and rdy=1 immediately, no ack. After release, a pending req is granted from channel 0.
